rx_crc_check: RTL

RX_CRC_CHECK -- requirements
Module: rx_crc_check

---
 rtl/rx_crc_check_pkg.sv | 36 +++
 rtl/crc32_lanes.sv | 41 ++++
 rtl/rx_crc_check.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rx_crc_check_pkg.sv
// ---------------------------------------------------------------------------
// rx_crc_check_pkg
//
// Shared definitions for the receive-side Ethernet CRC-32 checker:
//   - CRC32_POLY    : reflected Ethernet polynomial
//   - CRC32_INIT    : register seed at the start of every frame
//   - CRC32_RESIDUE : register value left after running a good frame
//                     through the CRC together with its own FCS bytes
//   - state_t / ST_*: checker FSM state encoding
//   - crc32_byte()  : one-byte, LSB-first CRC-32 update
// ---------------------------------------------------------------------------
package rx_crc_check_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_CHECK = 2'd2;

    // The register holds the CRC in reflected form, so each data bit
    // enters at bit 0 and the register shifts right.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_lanes.sv
// ---------------------------------------------------------------------------
// crc32_lanes
//
// Combinational multi-lane CRC-32 update. Folds the first lane_count bytes
// of a beat (lane 0 first) into the incoming CRC. A lane_count of zero
// passes the CRC through unchanged.
//
// Ports:
//   crc_in     [31:0]              CRC before this beat
//   data       [DATA_BYTES*8-1:0]  beat data, lane 0 in data[7:0]
//   lane_count [LCW-1:0]           number of leading lanes to process
//   crc_out    [31:0]              CRC after this beat
// ---------------------------------------------------------------------------
module crc32_lanes
    import rx_crc_check_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    localparam int LCW       = $clog2(DATA_BYTES + 1)
) (
    input  logic [31:0]             crc_in,
    input  logic [DATA_BYTES*8-1:0] data,
    input  logic [LCW-1:0]          lane_count,
    output logic [31:0]             crc_out
);

    logic [31:0] acc;

    // Unrolled byte chain; lanes at or beyond lane_count are skipped so a
    // partial eof beat only contributes its valid bytes.
    always_comb begin
        acc = crc_in;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(lane_count)) begin
                acc = crc32_byte(acc, data[i*8 +: 8]);
            end
        end
    end

    assign crc_out = acc;

endmodule

// File: rtl/rx_crc_check.sv
// ---------------------------------------------------------------------------
// rx_crc_check
//
// Receive-side Ethernet CRC-32 checker. Accumulates the CRC over the valid
// lanes of each beat of a frame and, two cycles after the eof beat, pulses
// either crc_check_valid or crc_check_invalid. Bad frames are counted in a
// saturating error counter.
//
// Parameters:
//   DATA_BYTES    lanes per beat (1, 2, 4, 8 or 16)
//   RESIDUE_MODE  0: compare ~CRC with fcs_in latched at eof
//                 1: FCS travels in the data stream, check the CRC residue
//   CNT_WIDTH     error counter width
//
// Ports:
//   rxclk              clock, all state changes on its rising edge
//   reset              asynchronous active-high reset
//   rxd                beat data, lane 0 in rxd[7:0] is first on the wire
//   rx_valid           lane enables, contiguous from lane 0
//   sof                first beat of a frame (needs rx_valid != 0)
//   eof                last beat of a frame
//   fcs_in             received FCS, sampled on the eof beat
//   clr_count          synchronous clear of crc_err_count
//   crc_check_valid    one-cycle pulse, frame CRC good
//   crc_check_invalid  one-cycle pulse, frame CRC bad
//   crc_err_count      saturating count of bad frames
//   busy               high while a frame is being accumulated or checked
// ---------------------------------------------------------------------------
module rx_crc_check
    import rx_crc_check_pkg::*;
#(
    parameter int DATA_BYTES   = 8,
    parameter int RESIDUE_MODE = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    rxclk,
    input  logic                    reset,
    input  logic [DATA_BYTES*8-1:0] rxd,
    input  logic [DATA_BYTES-1:0]   rx_valid,
    input  logic                    sof,
    input  logic                    eof,
    input  logic [31:0]             fcs_in,
    input  logic                    clr_count,
    output logic                    crc_check_valid,
    output logic                    crc_check_invalid,
    output logic [CNT_WIDTH-1:0]    crc_err_count,
    output logic                    busy
);

    localparam int LCW = $clog2(DATA_BYTES + 1);

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    crc_q;
    logic [31:0]    crc_d;
    logic [31:0]    fcs_q;
    logic [31:0]    fcs_d;
    logic [LCW-1:0] lane_count;
    logic           beat;
    logic           start;
    logic [31:0]    crc_base;
    logic [31:0]    crc_upd;
    logic           in_check;
    logic           fcs_ok;
    logic           residue_ok;
    logic           crc_good;
    logic           bad_frame;
    logic [CNT_WIDTH-1:0] count_d;

    // Lanes are contiguous from lane 0, so the number of set enables is
    // exactly how many leading bytes of the beat belong to the frame.
    always_comb begin
        lane_count = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_count = lane_count + LCW'(rx_valid[i]);
        end
    end

    assign beat  = |rx_valid;
    assign start = sof & beat;

    // A new frame starts from the seed value rather than the running CRC,
    // which lets the sof beat be seeded and folded in the same cycle.
    assign crc_base = start ? CRC32_INIT : crc_q;

    crc32_lanes #(
        .DATA_BYTES (DATA_BYTES)
    ) u_lanes (
        .crc_in     (crc_base),
        .data       (rxd),
        .lane_count (lane_count),
        .crc_out    (crc_upd)
    );

    // Frame sequencing. A qualified sof wins in every state: in IDLE it
    // opens a frame, in ACCUM it abandons the current one, and in CHECK
    // it overlaps the result cycle of the previous frame. An eof with no
    // valid lanes closes the frame on the CRC of the prior beat.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        fcs_d   = fcs_q;
        if (start) begin
            crc_d   = crc_upd;
            state_d = eof ? ST_CHECK : ST_ACCUM;
            if (eof) begin
                fcs_d = fcs_in;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    crc_d = crc_upd;
                    if (eof) begin
                        state_d = ST_CHECK;
                        fcs_d   = fcs_in;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The check uses the registered CRC, which still holds the finished
    // frame even if a new sof is reseeding crc_d in the same cycle.
    assign in_check   = (state_q == ST_CHECK);
    assign fcs_ok     = (~crc_q == fcs_q);
    assign residue_ok = (crc_q == CRC32_RESIDUE);
    assign crc_good   = (RESIDUE_MODE != 0) ? residue_ok : fcs_ok;
    assign bad_frame  = in_check & ~crc_good;

    // Clear takes priority but still counts a bad frame landing on the
    // same edge, so that frame is not lost from the statistics.
    always_comb begin
        count_d = crc_err_count;
        if (clr_count) begin
            count_d = bad_frame ? CNT_WIDTH'(1) : '0;
        end else if (bad_frame && (crc_err_count != {CNT_WIDTH{1'b1}})) begin
            count_d = crc_err_count + CNT_WIDTH'(1);
        end
    end

    // All outputs are registered so the result pulse lands two cycles
    // after the eof beat and busy follows the state being entered.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            crc_q             <= CRC32_INIT;
            fcs_q             <= '0;
            crc_check_valid   <= 1'b0;
            crc_check_invalid <= 1'b0;
            crc_err_count     <= '0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_d;
            crc_q             <= crc_d;
            fcs_q             <= fcs_d;
            crc_check_valid   <= in_check & crc_good;
            crc_check_invalid <= bad_frame;
            crc_err_count     <= count_d;
            busy              <= (state_d != ST_IDLE);
        end
    end

endmodule
